multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// multicycle_controller
//   Control FSM for a multi-cycle RV32I core with one shared ALU and one
//   unified instruction/data memory. Each instruction walks through
//   FETCH / DECODE / EXECUTE / MEM / WB states; this block drives the
//   datapath selects, write enables and ALUControl.
//
// Optional build macro: MCC_INSTRET_EN adds a 32-bit retired-instruction
//   counter output (instret) that counts instr_done pulses and wraps.
//
// Parameters:
//   FETCH_WAIT_MAX  FETCH cycles without mem_ready before err_timeout
//                   pulses; 0 disables the watchdog.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields from IR
//   Zero, SltOut          ALU flags used for branch resolution
//   mem_ready             memory finished the current access this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl  datapath selects
//   instr_done            pulse in the last state of each instruction
//   err_timeout           pulse when the fetch watchdog expires
//   instret               (MCC_INSTRET_EN only) retired-instruction count
module multicycle_controller #(
    parameter int FETCH_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        SltOut,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        RegWrite,
    output logic        instr_done,
    output logic        err_timeout
`ifdef MCC_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t     r_state, w_next;
    logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_done;
    logic       w_adrsrc;
    logic [1:0] w_resultsrc, w_srca, w_srcb;
    logic [2:0] w_immsrc, w_aluctl, w_alu_func;
    logic       w_br_take;
    logic       w_wd_fire;

    // Arithmetic op selection shared by EXECR and EXECI; only the register
    // form may turn add into sub (IR[30] is part of the immediate for addi).
    always_comb begin
        w_alu_func = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_func = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_func = ALU_SLT;
            3'b100:  w_alu_func = ALU_XOR;
            3'b110:  w_alu_func = ALU_OR;
            3'b111:  w_alu_func = ALU_AND;
            default: w_alu_func = ALU_ADD;
        endcase
    end

    always_comb begin
        w_br_take = 1'b0;
        case (funct3)
            3'b000:  w_br_take = Zero;
            3'b001:  w_br_take = ~Zero;
            3'b100:  w_br_take = SltOut;
            3'b101:  w_br_take = ~SltOut;
            default: w_br_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_resultsrc = 2'b00;
        w_srca      = 2'b00;
        w_srcb      = 2'b00;
        w_immsrc    = IMM_I;
        w_aluctl    = ALU_ADD;
        w_regwrite  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_srcb      = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = mem_ready;
                w_pcwrite   = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target OldPC + imm into ALUOut.
                w_srca = 2'b01;
                w_srcb = 2'b01;
                case (op)
                    OP_JAL:   w_immsrc = IMM_J;
                    OP_STORE: w_immsrc = IMM_S;
                    OP_BR:    w_immsrc = IMM_B;
                    default:  w_immsrc = IMM_I;
                endcase
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
                        // Unsupported opcode retires as a NOP.
                        w_done = 1'b1;
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_srca   = 2'b10;
                w_srcb   = 2'b01;
                w_immsrc = op[5] ? IMM_S : IMM_I;
                w_next   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_done     = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_srca   = 2'b10;
                w_srcb   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_aluctl = w_alu_func;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut still holds the target from DECODE; the ALU compares rs1/rs2.
                w_srca    = 2'b10;
                w_aluctl  = (funct3 == 3'b100 || funct3 == 3'b101) ? ALU_SLT : ALU_SUB;
                w_pcwrite = w_br_take;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                // PC <= target (ALUOut); ALU makes OldPC+4 for the link write.
                w_srca    = 2'b01;
                w_srcb    = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_JALR: begin
                w_srca      = 2'b10;
                w_srcb      = 2'b01;
                w_resultsrc = 2'b10;
                w_pcwrite   = 1'b1;
                w_next      = S_JALRWB;
            end
            S_JALRWB: begin
                w_srca      = 2'b01;
                w_srcb      = 2'b10;
                w_resultsrc = 2'b10;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_LUI: begin
                w_immsrc    = IMM_U;
                w_resultsrc = 2'b11;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Fetch watchdog: fires on the FETCH_WAIT_MAX-th consecutive stalled
    // FETCH cycle, then restarts counting while remaining in FETCH.
    generate
        if (FETCH_WAIT_MAX > 0) begin : g_wd
            localparam int CW = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX) : 1;
            logic [CW-1:0] r_wd_cnt;
            assign w_wd_fire = (r_state == S_FETCH) && !mem_ready &&
                               (r_wd_cnt == CW'(FETCH_WAIT_MAX - 1));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_wd_cnt <= '0;
                else if (r_state == S_FETCH && !mem_ready && !w_wd_fire)
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                else
                    r_wd_cnt <= '0;
            end
        end else begin : g_no_wd
            assign w_wd_fire = 1'b0;
        end
    endgenerate

    // Enables are gated by rst_n so nothing writes once reset falls, even
    // though FETCH itself would pass mem_ready through.
    assign PCWrite     = w_pcwrite  & rst_n;
    assign IRWrite     = w_irwrite  & rst_n;
    assign RegWrite    = w_regwrite & rst_n;
    assign MemWrite    = w_memwrite & rst_n;
    assign instr_done  = w_done     & rst_n;
    assign err_timeout = w_wd_fire  & rst_n;
    assign AdrSrc      = w_adrsrc;
    assign ResultSrc   = w_resultsrc;
    assign ALUSrcA     = w_srca;
    assign ALUSrcB     = w_srcb;
    assign ImmSrc      = w_immsrc;
    assign ALUControl  = w_aluctl;

`ifdef MCC_INSTRET_EN
    logic [31:0] r_instret;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_instret <= '0;
        else if (instr_done) r_instret <= r_instret + 32'd1;
    end
    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, SltOut, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, err_timeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
`ifdef MCC_INSTRET_EN
    logic [31:0] instret;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.FETCH_WAIT_MAX(5)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .SltOut(SltOut), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .instr_done(instr_done),
        .err_timeout(err_timeout)
`ifdef MCC_INSTRET_EN
        , .instret(instret)
`endif
    );

    // One expected cycle: the mem_ready value to drive plus every output.
    typedef struct packed {
        logic       mr;
        logic       pcw, adr, memw, irw;
        logic [1:0] rs, a, b;
        logic [2:0] imm, alu;
        logic       rw, done, err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] exp_ir = 32'd0;

    function automatic logic [2:0] alu_of(logic rtype, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (rtype && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t fetch_rec(logic mr, logic err);
        exp_t e;
        e = '0; e.mr = mr; e.b = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; e.err = err;
        return e;
    endfunction

    function automatic exp_t wb_rec();
        exp_t e;
        e = '0; e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction

    // Expected cycle sequence of one instruction, from fetch to retirement.
    task automatic gen(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic s, input int fw, input int mw);
        exp_t e;
        logic known, take, st;
        for (int k = 1; k <= fw; k++) q.push_back(fetch_rec(1'b0, (k % 5) == 0));
        q.push_back(fetch_rec(1'b1, 1'b0));
        known = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111) ||
                (o == 7'b1100111) || (o == 7'b0110111);
        e = '0; e.a = 2'b01; e.b = 2'b01;
        e.imm = (o == 7'b1101111) ? 3'b011 : (o == 7'b0100011) ? 3'b001 :
                (o == 7'b1100011) ? 3'b010 : 3'b000;
        e.done = !known;
        q.push_back(e);
        if (known) begin
            case (o)
                7'b0000011, 7'b0100011: begin
                    st = (o == 7'b0100011);
                    e = '0; e.a = 2'b10; e.b = 2'b01; e.imm = st ? 3'b001 : 3'b000;
                    q.push_back(e);
                    for (int k = 0; k < mw; k++) begin
                        e = '0; e.adr = 1'b1; e.memw = st; q.push_back(e);
                    end
                    e = '0; e.mr = 1'b1; e.adr = 1'b1; e.memw = st; e.done = st;
                    q.push_back(e);
                    if (!st) begin
                        e = '0; e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; q.push_back(e);
                    end
                end
                7'b0110011, 7'b0010011: begin
                    e = '0; e.a = 2'b10; e.b = (o == 7'b0010011) ? 2'b01 : 2'b00;
                    e.alu = alu_of(o == 7'b0110011, f3, f7);
                    q.push_back(e);
                    q.push_back(wb_rec());
                end
                7'b1100011: begin
                    case (f3)
                        3'b000:  take = z;
                        3'b001:  take = !z;
                        3'b100:  take = s;
                        3'b101:  take = !s;
                        default: take = 1'b0;
                    endcase
                    e = '0; e.a = 2'b10; e.pcw = take; e.done = 1'b1;
                    e.alu = (f3 == 3'b100 || f3 == 3'b101) ? 3'b101 : 3'b001;
                    q.push_back(e);
                end
                7'b1101111: begin
                    e = '0; e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; q.push_back(e);
                    q.push_back(wb_rec());
                end
                7'b1100111: begin
                    e = '0; e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; q.push_back(e);
                    e = '0; e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10; e.rw = 1'b1; e.done = 1'b1;
                    q.push_back(e);
                end
                default: begin
                    e = '0; e.imm = 3'b100; e.rs = 2'b11; e.rw = 1'b1; e.done = 1'b1;
                    q.push_back(e);
                end
            endcase
        end
    endtask

    task automatic chk(input string nm, input exp_t e);
        exp_t act;
        act = '0;
        act.mr = mem_ready; act.pcw = PCWrite; act.adr = AdrSrc; act.memw = MemWrite;
        act.irw = IRWrite; act.rs = ResultSrc; act.a = ALUSrcA; act.b = ALUSrcB;
        act.imm = ImmSrc; act.alu = ALUControl; act.rw = RegWrite; act.done = instr_done;
        act.err = err_timeout;
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s got=%b need=%b (mr pcw adr memw irw rs a b imm alu rw done err)",
                     nm, act, e);
        end
    endtask

    task automatic pin(input string nm, input int got, input int need);
        n_chk++;
        if (got != need) begin
            n_fail++;
            $display("FAIL %s got=%0d need=%0d", nm, got, need);
        end
    endtask

    // Entered #1 after a clock edge; each iteration covers one clock cycle.
    task automatic run(input string tag, input int max);
        exp_t e;
        for (int i = 0; i < max && q.size() > 0; i++) begin
            e = q.pop_front();
            mem_ready = e.mr;
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), e);
            if (e.done) exp_ir = exp_ir + 32'd1;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic setin(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; SltOut = s;
    endtask

    task automatic instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input logic s,
                         input int fw, input int mw);
        setin(o, f3, f7, z, s);
        gen(o, f3, f7, z, s, fw, mw);
        run(tag, 1000);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; mem_ready = 1'b1;
        setin(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        #12;
        // Enables stay low in reset even with mem_ready high.
        e = fetch_rec(1'b0, 1'b0); e.mr = 1'b1;
        chk("reset", e);
`ifdef MCC_INSTRET_EN
        pin("reset_instret", int'(instret), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;

        // add: 4 cycles, RegWrite/instr_done only in the 4th
        setin(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        gen(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        pin("model_add_len", q.size(), 4);
        pin("model_add_wb", int'(q[3].rw && q[3].done && !q[2].rw), 1);
        run("add", 1000);

        setin(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
        gen(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
        pin("model_sub_alu", int'(q[2].alu), 1);
        run("sub", 1000);

        setin(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
        gen(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
        pin("model_addi_alu", int'(q[2].alu), 0);
        run("addi_b30", 1000);

        instr("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("xori", 7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1, 0);
        instr("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("sll",  7'b0110011, 3'b001, 1'b1, 1'b0, 1'b0, 0, 0);

        // lw: 2 fetch stalls, MEMREAD held 4 cycles (3 stalls)
        setin(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        gen(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2, 3);
        pin("model_lw_len", q.size(), 10);
        pin("model_lw_wb", int'(q[8].mr && q[9].rw), 1);
        run("lw", 1000);

        instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2);
        instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
        instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("bne_t",   7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("blt_t",   7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);
        instr("bge_t",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("bge_nt",  7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0);
        instr("b010",    7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0);
        instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("jalr",    7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("lui",     7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        instr("bad_op",  7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        // Watchdog: pulses on the 5th and 10th stalled FETCH cycles
        instr("wdog",    7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 11, 0);

        // Reset while MEMWRITE is stalled: MemWrite must fall without a clock.
        setin(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        gen(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
        run("sw_rst", 4);
        #2;
        pin("sw_pre_rst_memwrite", int'(MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("sw_async_rst", fetch_rec(1'b0, 1'b0));
        q.delete();
        exp_ir = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        instr("add_after_rst", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef MCC_INSTRET_EN
        pin("instret", int'(instret), int'(exp_ir));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
